// File: rtl/vga_text_pkg.sv
// Shared text-mode constants for the VGA console writer and the scan-out engine.
// Holds the screen geometry, the vmem layout of the text buffer, the control
// codes the writer decodes, and the writer state encoding.
package vga_text_pkg;

  localparam int unsigned COLS         = 80;
  localparam int unsigned ROWS         = 60;
  localparam int unsigned VMEMSTART    = 1024;
  localparam int unsigned AW           = 13;
  localparam int unsigned ROWW         = 6;
  localparam int unsigned COLW         = 7;
  localparam int unsigned CELLS        = COLS * ROWS;
  localparam int unsigned VMEMEND      = VMEMSTART + CELLS;
  localparam int unsigned SCROLL_CELLS = COLS * (ROWS - 1);

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SO = 8'h0E;
  localparam logic [7:0] CH_SI = 8'h0F;

  typedef enum logic [2:0] {
    CLR_ALL,
    IDLE,
    PUT,
    SCR_RD,
    SCR_WR,
    CLR_ROW
  } state_t;

endpackage

// File: rtl/vga_cursor_addr.sv
// Cursor row/column counters and cell address generation.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   home                cursor to 0/0
//   step                advance after a printed glyph (wraps at the last column)
//   newline             column 0, next row
//   cr                  column 0
//   bs                  column - 1 unless already at column 0
//   row, col            registered cursor position
//   addr_c              vmem address of the cursor cell
//   addr_bs_c           vmem address of the cell left of the cursor
//   wrap_c              cursor sits in the last column
//   scroll_c            cursor sits in the last row: a row advance needs a scroll
import vga_text_pkg::*;

module vga_cursor_addr (
  input  logic                clk,
  input  logic                rst,
  input  logic                home,
  input  logic                step,
  input  logic                newline,
  input  logic                cr,
  input  logic                bs,
  output logic [ROWW-1:0]     row,
  output logic [COLW-1:0]     col,
  output logic [AW-1:0]       addr_c,
  output logic [AW-1:0]       addr_bs_c,
  output logic                wrap_c,
  output logic                scroll_c
);

  logic [ROWW-1:0] row_inc;

  assign wrap_c    = (col == COLW'(COLS - 1));
  assign scroll_c  = (row == ROWW'(ROWS - 1));
  // The last row never advances; the top module scrolls the buffer instead.
  assign row_inc   = scroll_c ? row : row + ROWW'(1);
  assign addr_c    = AW'(VMEMSTART) + AW'(row) * AW'(COLS) + AW'(col);
  assign addr_bs_c = addr_c - AW'(1);

  // Cursor position register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (home) begin
      row <= '0;
      col <= '0;
    end else if (newline) begin
      row <= row_inc;
      col <= '0;
    end else if (cr) begin
      col <= '0;
    end else if (bs) begin
      if (col != '0) col <= col - COLW'(1);
    end else if (step) begin
      if (wrap_c) begin
        row <= row_inc;
        col <= '0;
      end else begin
        col <= col + COLW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_console_writer.sv
// Terminal-style writer for the 80x60 text buffer in vmem.
// Accepts bytes over valid/ready, prints glyphs at the cursor, decodes
// BS/LF/FF/CR, and scrolls by copying rows up and blanking the last row.
// Optional feature macro: CONSOLE_ATTR_EN (SO/SI set/clear a sticky attribute
// bit that is ORed into bit 7 of printed glyphs).
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_data/in_valid    byte stream in; in_ready high only in IDLE
//   vmem_addr/we/wdata  vmem port; addr and we registered
//   vmem_rdata          vmem read data, one cycle after the address
//   cursor_row/col      registered cursor position
//   busy                scroll or clear in progress
import vga_text_pkg::*;

module vga_console_writer (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [AW-1:0]   vmem_addr,
  output logic [7:0]      vmem_wdata,
  output logic            vmem_we,
  input  logic [7:0]      vmem_rdata,
  output logic [ROWW-1:0] cursor_row,
  output logic [COLW-1:0] cursor_col,
  output logic            busy
);

  state_t        state, state_d;
  logic [AW-1:0] cnt, cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic [AW-1:0] addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          we_d;
  logic          cmd_home, cmd_step, cmd_newline, cmd_cr, cmd_bs, row_adv;
  logic [AW-1:0] cell_addr_c, bs_addr_c;
  logic          wrap_c, scroll_c;
  logic [7:0]    glyph_c;

`ifdef CONSOLE_ATTR_EN
  logic attr, attr_d;
  assign glyph_c = {in_data[7] | attr, in_data[6:0]};
`else
  assign glyph_c = in_data;
`endif

  function automatic logic is_ctrl(input logic [7:0] b);
    is_ctrl = (b == CH_BS) || (b == CH_LF) || (b == CH_FF) || (b == CH_CR)
`ifdef CONSOLE_ATTR_EN
              || (b == CH_SO) || (b == CH_SI)
`endif
              ;
  endfunction

  vga_cursor_addr u_cursor (
    .clk       (clk),
    .rst       (rst),
    .home      (cmd_home),
    .step      (cmd_step),
    .newline   (cmd_newline),
    .cr        (cmd_cr),
    .bs        (cmd_bs),
    .row       (cursor_row),
    .col       (cursor_col),
    .addr_c    (cell_addr_c),
    .addr_bs_c (bs_addr_c),
    .wrap_c    (wrap_c),
    .scroll_c  (scroll_c)
  );

  // The copy data comes straight from the BRAM read port during SCR_WR so a
  // row copy keeps to two cycles per cell on the single vmem port.
  assign vmem_wdata = (state == SCR_WR) ? vmem_rdata : wdata_q;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= CLR_ALL;
      cnt       <= '0;
      byte_q    <= '0;
      vmem_addr <= AW'(VMEMSTART);
      wdata_q   <= '0;
      vmem_we   <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
`ifdef CONSOLE_ATTR_EN
      attr      <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      byte_q    <= byte_d;
      vmem_addr <= addr_d;
      wdata_q   <= wdata_d;
      vmem_we   <= we_d;
      in_ready  <= (state_d == IDLE);
      busy      <= (state_d != IDLE) && (state_d != PUT);
`ifdef CONSOLE_ATTR_EN
      attr      <= attr_d;
`endif
    end
  end

  // Next state; vmem controls are computed for the cycle being entered so the
  // registered port shows the access belonging to the current state.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    byte_d      = byte_q;
    addr_d      = vmem_addr;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    cmd_home    = 1'b0;
    cmd_step    = 1'b0;
    cmd_newline = 1'b0;
    cmd_cr      = 1'b0;
    cmd_bs      = 1'b0;
    row_adv     = 1'b0;
`ifdef CONSOLE_ATTR_EN
    attr_d      = attr;
`endif
    unique case (state)
      CLR_ALL: begin
        if (cnt == AW'(CELLS)) begin
          state_d = IDLE;
        end else begin
          addr_d  = AW'(VMEMSTART) + cnt;
          wdata_d = BLANK;
          we_d    = 1'b1;
          cnt_d   = cnt + AW'(1);
        end
      end
      IDLE: begin
        if (in_valid) begin
          byte_d  = in_data;
          state_d = PUT;
          if (in_data == CH_BS) begin
            if (cursor_col != '0) begin
              addr_d  = bs_addr_c;
              wdata_d = BLANK;
              we_d    = 1'b1;
            end
          end else if (!is_ctrl(in_data)) begin
            addr_d  = cell_addr_c;
            wdata_d = glyph_c;
            we_d    = 1'b1;
          end
        end
      end
      PUT: begin
        state_d = IDLE;
        case (byte_q)
          CH_FF: begin
            // Cell 0 is issued here so the clear takes exactly CELLS cycles.
            cmd_home = 1'b1;
            state_d  = CLR_ALL;
            addr_d   = AW'(VMEMSTART);
            wdata_d  = BLANK;
            we_d     = 1'b1;
            cnt_d    = AW'(1);
          end
          CH_LF: begin
            cmd_newline = 1'b1;
            row_adv     = 1'b1;
          end
          CH_CR: cmd_cr = 1'b1;
          CH_BS: cmd_bs = 1'b1;
`ifdef CONSOLE_ATTR_EN
          CH_SO: attr_d = 1'b1;
          CH_SI: attr_d = 1'b0;
`endif
          default: begin
            cmd_step = 1'b1;
            row_adv  = wrap_c;
          end
        endcase
        if (row_adv && scroll_c) begin
          state_d = SCR_RD;
          cnt_d   = '0;
          addr_d  = AW'(VMEMSTART + COLS);
        end
      end
      SCR_RD: begin
        state_d = SCR_WR;
        addr_d  = AW'(VMEMSTART) + cnt;
        we_d    = 1'b1;
      end
      SCR_WR: begin
        if (cnt == AW'(SCROLL_CELLS - 1)) begin
          state_d = CLR_ROW;
          cnt_d   = '0;
          addr_d  = AW'(VMEMSTART + SCROLL_CELLS);
          wdata_d = BLANK;
          we_d    = 1'b1;
        end else begin
          state_d = SCR_RD;
          cnt_d   = cnt + AW'(1);
          addr_d  = AW'(VMEMSTART + COLS) + cnt + AW'(1);
        end
      end
      CLR_ROW: begin
        if (cnt == AW'(COLS - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt + AW'(1);
          addr_d  = AW'(VMEMSTART + SCROLL_CELLS) + cnt + AW'(1);
          wdata_d = BLANK;
          we_d    = 1'b1;
        end
      end
      default: state_d = CLR_ALL;
    endcase
  end

endmodule

// File: tb/tb_vga_console_writer.sv
// Self-checking bench for vga_console_writer: sync BRAM model, console model
// feeding an expected-write scoreboard, and directed checks of cursor, timing
// and final buffer contents.
module tb_vga_console_writer;

`ifdef CONSOLE_ATTR_EN
  localparam bit ATTR = 1'b1;
`else
  localparam bit ATTR = 1'b0;
`endif
  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] vmem_addr;
  logic [7:0]  vmem_wdata;
  logic        vmem_we;
  logic [7:0]  vmem_rdata;
  logic [5:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  logic        bd_we = 1'b0;
  logic [12:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  logic [7:0]  mem  [0:8191];
  logic [7:0]  mmem [0:8191];
  logic [20:0] sb [$];
  int          checks = 0;
  int          errors = 0;
  int          mrow = 0;
  int          mcol = 0;
  bit          mattr = 1'b0;

  vga_console_writer dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .vmem_addr  (vmem_addr),
    .vmem_wdata (vmem_wdata),
    .vmem_we    (vmem_we),
    .vmem_rdata (vmem_rdata),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Synchronous BRAM, read-before-write, with a backdoor write port
  always @(posedge clk) begin
    vmem_rdata <= mem[vmem_addr];
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (vmem_we) mem[vmem_addr] <= vmem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every DUT write must match the next expected write
  always @(negedge clk) begin
    if (vmem_we) begin
      if (sb.size() == 0) begin
        check("sb_extra_write", {11'h0, vmem_addr, vmem_wdata}, 32'hFFFF_FFFF);
      end else begin
        logic [20:0] e;
        e = sb.pop_front();
        check("vmem_write", {11'h0, vmem_addr, vmem_wdata}, {11'h0, e});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic expect_wr(input int a, input logic [7:0] d);
    sb.push_back({13'(a), d});
    mmem[a] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4800; i++) expect_wr(1024 + i, 8'h20);
    mrow = 0;
    mcol = 0;
  endtask

  task automatic model_newrow();
    if (mrow < 59) begin
      mrow++;
    end else begin
      for (int i = 0; i < 4720; i++) expect_wr(1024 + i, mmem[1104 + i]);
      for (int j = 0; j < 80; j++) expect_wr(5744 + j, 8'h20);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'h0C) model_clear();
    else if (ATTR && b == 8'h0E) mattr = 1'b1;
    else if (ATTR && b == 8'h0F) mattr = 1'b0;
    else if (b == 8'h0A) begin mcol = 0; model_newrow(); end
    else if (b == 8'h0D) mcol = 0;
    else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        expect_wr(1024 + mrow * 80 + mcol, 8'h20);
      end
    end else begin
      expect_wr(1024 + mrow * 80 + mcol, {b[7] | mattr, b[6:0]});
      if (mcol == 79) begin mcol = 0; model_newrow(); end
      else mcol++;
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_row"}, 32'(cursor_row), 32'(mrow));
    check({tag, "_col"}, 32'(cursor_col), 32'(mcol));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit wait_done, output int nbusy);
    int n;
    model_byte(b);
    wait_ready(n);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    nbusy = 0;
    if (wait_done) begin
      n = 0;
      @(negedge clk);
      while (!in_ready && n < LIMIT) begin
        if (busy) nbusy++;
        @(negedge clk);
        n++;
      end
      check("done_timeout", 32'(in_ready), 32'd1);
    end
  endtask

  task automatic send_n(input logic [7:0] b, input int count);
    int nb;
    for (int i = 0; i < count; i++) send_byte(b, 1'b1, nb);
  endtask

  task automatic preload_row(input int base, input logic [7:0] v);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      bd_addr = 13'(base + i);
      bd_data = v;
      bd_we   = 1'b1;
      mmem[base + i] = v;
    end
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  function automatic int count_ne(input int lo, input int hi, input logic [7:0] v);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (mem[i] !== v) c++;
    return c;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"}, 32'(vmem_we), 32'd0);
    check({tag, "_addr"}, 32'(vmem_addr), 32'd1024);
    check({tag, "_wdata"}, 32'(vmem_wdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cursor"}, 32'({cursor_row, cursor_col}), 32'd0);
  endtask

  initial begin
    int n;
    int nb;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Byte held valid through the power-up clear must not be lost
    model_clear();
    model_byte(8'h41);
    in_data  = 8'h41;
    in_valid = 1'b1;
    rst      = 1'b1;
    wait_ready(n);
    check("init_clear_len_ok", 32'(n >= 4800 && n <= 4802), 32'd1);
    check("init_blank", 32'(count_ne(1024, 5823, 8'h20)), 32'd0);
    check("init_cursor", 32'({cursor_row, cursor_col}), 32'd0);
    @(negedge clk);
    check("put_not_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("next_accept_2cyc", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    check_cursor("after_A");
    check("cell_A", 32'(mem[1024]), 32'h41);

    // Fill row 0, wrap to row 1, then BS at column 0 is a no-op
    send_byte(8'h0D, 1'b1, nb);
    send_n(8'h42, 80);
    check("row0_B", 32'(count_ne(1024, 1103, 8'h42)), 32'd0);
    check("wrap_cursor", 32'({cursor_row, cursor_col}), 32'({6'd1, 7'd0}));
    send_byte(8'h08, 1'b1, nb);
    check_cursor("bs_col0");

    // BS mid-row blanks the previous cell
    send_n(8'h43, 3);
    send_byte(8'h08, 1'b1, nb);
    check_cursor("bs_mid");
    check("bs_blank", 32'(mem[1106]), 32'h20);
    send_byte(8'h0D, 1'b1, nb);

    // Scroll from 59/5 with rows 1 and 59 preloaded
    send_n(8'h0A, 58);
    send_n(8'h78, 5);
    check("pre_scroll_cursor", 32'({cursor_row, cursor_col}), 32'({6'd59, 7'd5}));
    preload_row(1104, 8'h31);
    preload_row(5744, 8'h39);
    send_byte(8'h0A, 1'b1, nb);
    check("scroll_busy_len", 32'(nb), 32'd9520);
    check("scroll_row0", 32'(count_ne(1024, 1103, 8'h31)), 32'd0);
    check("scroll_row58", 32'(count_ne(5664, 5743, 8'h39)), 32'd0);
    check("scroll_row59", 32'(count_ne(5744, 5823, 8'h20)), 32'd0);
    check("scroll_cursor", 32'({cursor_row, cursor_col}), 32'({6'd59, 7'd0}));
    check("sb_drained_scroll", 32'(sb.size()), 32'd0);

    // Form feed mid-screen
    send_byte(8'h5A, 1'b1, nb);
    send_byte(8'h0C, 1'b1, nb);
    check("ff_busy_len", 32'(nb), 32'd4800);
    check("ff_blank", 32'(count_ne(1024, 5823, 8'h20)), 32'd0);
    check("ff_cursor", 32'({cursor_row, cursor_col}), 32'd0);

    // SO/SI handling depends on the attribute build
    send_byte(8'h0E, 1'b1, nb);
    send_byte(8'h41, 1'b1, nb);
    send_byte(8'h0F, 1'b1, nb);
    send_byte(8'h41, 1'b1, nb);
    if (ATTR) begin
      check("attr_c1", 32'(mem[1024]), 32'hC1);
      check("attr_41", 32'(mem[1025]), 32'h41);
      check("attr_col", 32'(cursor_col), 32'd2);
    end else begin
      check("plain_0e", 32'(mem[1024]), 32'h0E);
      check("plain_41", 32'(mem[1025]), 32'h41);
      check("plain_0f", 32'(mem[1026]), 32'h0F);
      check("plain_41b", 32'(mem[1027]), 32'h41);
      check("plain_col", 32'(cursor_col), 32'd4);
    end
    check_cursor("so_si");

    // Reset in the middle of a scroll aborts it and restarts the full clear
    send_byte(8'h0D, 1'b1, nb);
    send_n(8'h0A, 59);
    send_byte(8'h0A, 1'b0, nb);
    repeat (200) @(negedge clk);
    check("mid_scroll_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_reset");
    sb.delete();
    mattr = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_ready(n);
    check("reclear_len_ok", 32'(n >= 4800 && n <= 4802), 32'd1);
    check("reclear_blank", 32'(count_ne(1024, 5823, 8'h20)), 32'd0);
    check_cursor("reclear");
    check("sb_drained_end", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_console_writer.md
Name: vga_console_writer

Overview:
Terminal-style character sink that writes the 80x60 text buffer of video memory, i.e. the writer side of the VGA text scan-out engine. It accepts an ASCII byte stream over valid/ready, places glyph codes at the cursor, handles control characters, and hardware-scrolls the buffer by copying rows up and blanking the last row. It owns one dedicated vmem port; font rows (0-1023) are never touched.

Parameters:
COLS, 80, characters per row
ROWS, 60, character rows
VMEMSTART, 1024, vmem address of cell (row 0, col 0)
AW, 13, vmem address width
BLANK, 8'h20, fill byte for cleared cells

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  asynchronous active-low reset
in_data  input  8  byte to print
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a byte this cycle
vmem_addr  output  AW  vmem address
vmem_wdata  output  8  vmem write data
vmem_we  output  1  vmem write strobe
vmem_rdata  input  8  vmem read data, valid 1 cycle after address (sync BRAM)
cursor_row  output  6  current row, 0..ROWS-1
cursor_col  output  7  current column, 0..COLS-1
busy  output  1  scroll or clear in progress

Behaviour:
- Reset is asynchronous and active-low on rst, single clock clk. During reset: in_ready=0, vmem_we=0, vmem_addr=VMEMSTART, vmem_wdata=0, cursor 0/0, busy=0, state CLR_ALL.
- States: CLR_ALL, IDLE, PUT, SCR_RD, SCR_WR, CLR_ROW.
- CLR_ALL: writes BLANK to VMEMSTART..VMEMSTART+COLS*ROWS-1, one cell per cycle (4800 cycles); busy=1; cursor 0/0; then IDLE. Entered after reset release and on 0x0C.
- IDLE: in_ready=1. Handshake completes on the rising edge with in_valid&in_ready; byte latched and state goes to PUT, in_ready=0. Maximum throughput is 1 byte / 2 cycles when no scroll occurs.
- PUT (one cycle) decodes the latched byte:
  - 0x0A LF: col=0, row+1.
  - 0x0D CR: col=0.
  - 0x08 BS: if col>0, col-1 and write BLANK at the new cell; at col 0 no-op (no reverse wrap).
  - 0x0C FF: go to CLR_ALL.
  - Any other byte: vmem_we=1, addr=VMEMSTART+row*COLS+col, wdata=byte (bit7 is the inverse/blink attribute, passed through). Then col+1; when col==COLS-1, col=0 and row+1.
  - Row advance when row==ROWS-1: row stays ROWS-1 and state goes to SCR_RD. Otherwise return to IDLE.
- Address arithmetic uses AW bits; row*COLS uses a constant multiply or shift-add, with no truncation for the defaults.
- Scroll, for i = 0..COLS*(ROWS-1)-1:
  - SCR_RD: addr=VMEMSTART+COLS+i, we=0.
  - SCR_WR: addr=VMEMSTART+i, wdata=vmem_rdata, we=1.
  - Then CLR_ROW writes BLANK to the last row (COLS cycles), then IDLE.
  - Total 2*4720+80 cycles; busy=1 throughout.
- in_ready=0 in every state except IDLE. in_valid held during busy is not lost; it is accepted on return to IDLE.
- Reset asserted mid-scroll or mid-clear aborts immediately; the full clear restarts after release.
- cursor_row and cursor_col are registered; they update on the cycle that leaves PUT.

Optional Feature:
CONSOLE_ATTR_EN.
- Defined: 0x0E sets the sticky attribute bit and 0x0F clears it; neither is written or moves the cursor. Printable bytes are written as {in_data[7]|attr, in_data[6:0]}. attr resets to 0 and is unaffected by FF.
- Undefined: 0x0E and 0x0F are ordinary printable bytes, and no attr register exists.

Decomposition:
- Package vga_text_pkg holds:
  - COLS, ROWS, VMEMSTART, VMEMEND=VMEMSTART+COLS*ROWS, BLANK.
  - Control-code constants CH_BS, CH_LF, CH_FF, CH_CR, CH_SO, CH_SI.
  - The state enum.
- Shared with the scan-out engine.
- One sub-module, vga_cursor_addr: holds row/col counters, computes the cell address, and flags wrap and scroll-needed. The FSM stays in the top module.

Test Plan:
- Reset, then hold in_valid -> in_ready=0 for 4800 cycles, all 4800 cells read back 0x20, then in_ready=1 and cursor 0/0.
- Send "A" (0x41) -> one vmem_we with addr 1024, wdata 0x41; cursor_col=1; next byte accepted 2 cycles after the first handshake.
- Send 80 x 0x42 -> last write at addr 1103; cursor 1/0. Then send 0x08 -> no write, cursor stays 1/0.
- Move cursor to 59/5, preload row 1 with 0x31 and row 59 with 0x39, send 0x0A -> busy for 9520 cycles. Afterwards addr 1024..1103 hold 0x31, 5744..5823 hold 0x20, cursor 59/0.
- Send 0x0C mid-screen -> full clear, cursor 0/0. Then assert rst during a scroll -> outputs take reset values asynchronously and a full clear follows.
- With CONSOLE_ATTR_EN: send 0x0E, 0x41, 0x0F, 0x41 -> writes 0xC1 at 1024 and 0x41 at 1025, cursor_col=2. Without the macro -> writes 0x0E, 0xC1... no: writes 0x0E, 0x41, 0x0F, 0x41 at 1024..1027.
